// File: rtl/basic_search_ctrl_if.sv
// rtl/basic_search_ctrl_if.sv - controller <-> basic-layer search datapath signal bundle
// master = sequencer side, slave = search engine side.
interface basic_search_ctrl_if #(
  parameter int SR_W  = 16,
  parameter int SR_H  = 16,
  parameter int SAD_W = 16
);
  localparam int CW = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam int RW = (SR_H > 1) ? $clog2(SR_H) : 1;

  logic             ref_begin_prepare;
  logic             pe_begin_prepare;
  logic [CW-1:0]    search_column_count;
  logic [RW-1:0]    search_row_count;
  logic             cand_valid;
  logic             sad_valid;
  logic [SAD_W-1:0] sad32x32;

  modport master (
    output ref_begin_prepare, pe_begin_prepare, search_column_count,
           search_row_count, cand_valid,
    input  sad_valid, sad32x32
  );

  modport slave (
    input  ref_begin_prepare, pe_begin_prepare, search_column_count,
           search_row_count, cand_valid,
    output sad_valid, sad32x32
  );
endinterface

// File: rtl/basic_search_ctrl.sv
// rtl/basic_search_ctrl.sv - basic-layer integer search sequencer with min-SAD tracking
// Optional early termination on a good-enough SAD: build with BSC_EARLY_TERM_EN.
module basic_search_ctrl #(
  parameter int SR_W     = 16,
  parameter int SR_H     = 16,
  parameter int REF_CYC  = 32,
  parameter int PE_CYC   = 8,
  parameter int PIPE_LAT = 4,
  parameter int SAD_W    = 16,
  localparam int CW = (SR_W > 1) ? $clog2(SR_W) : 1,
  localparam int RW = (SR_H > 1) ? $clog2(SR_H) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  basic_search_ctrl_if.master eng,
`ifdef BSC_EARLY_TERM_EN
  input  logic [SAD_W-1:0]    et_thresh,
  output logic                early_term,
`endif
  output logic                busy,
  output logic                done,
  output logic [SAD_W-1:0]    best_sad,
  output logic [CW-1:0]       best_mv_x,
  output logic [RW-1:0]       best_mv_y
);
  localparam int NCAND = SR_W * SR_H;
  localparam int FW    = $clog2(NCAND + PIPE_LAT + 1);
  localparam int TW    = $clog2(REF_CYC + PE_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_REF, S_PE, S_SEARCH, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CW-1:0]    col_q, col_d, rx_col_q, rx_col_d, min_x_q, min_x_d, best_x_q, best_x_d;
  logic [RW-1:0]    row_q, row_d, rx_row_q, rx_row_d, min_y_q, min_y_d, best_y_q, best_y_d;
  logic [FW-1:0]    inflight_q, inflight_d;
  logic [SAD_W-1:0] min_q, min_d, best_sad_q, best_sad_d;
  logic             ref_q, ref_d, pe_q, pe_d, cand_q, cand_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             accept, last_cand, et_hit;
`ifdef BSC_EARLY_TERM_EN
  logic             et_q, et_d, early_q, early_d;
`endif

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    col_d      = col_q;
    row_d      = row_q;
    rx_col_d   = rx_col_q;
    rx_row_d   = rx_row_q;
    min_d      = min_q;
    min_x_d    = min_x_q;
    min_y_d    = min_y_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    ref_d      = ref_q;
    pe_d       = pe_q;
    cand_d     = cand_q;
    done_d     = 1'b0;
`ifdef BSC_EARLY_TERM_EN
    et_d       = et_q;
    early_d    = early_q;
`endif

    // Results only count while a search owns the pipe and something is outstanding.
    accept = eng.sad_valid && (state_q == S_SEARCH || state_q == S_DRAIN) &&
             (inflight_q != '0 || cand_q);
    last_cand = cand_q && col_q == CW'(SR_W - 1) && row_q == RW'(SR_H - 1);
`ifdef BSC_EARLY_TERM_EN
    et_hit = accept && (eng.sad32x32 <= et_thresh);
`else
    et_hit = 1'b0;
`endif
    inflight_d = inflight_q + FW'(cand_q) - FW'(accept);

    if (accept) begin
      if (eng.sad32x32 < min_q) begin
        min_d   = eng.sad32x32;
        min_x_d = rx_col_q;
        min_y_d = rx_row_q;
      end
      if (rx_col_q == CW'(SR_W - 1)) begin
        rx_col_d = '0;
        rx_row_d = rx_row_q + RW'(1);
      end else begin
        rx_col_d = rx_col_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REF;
          ref_d   = 1'b1;
          tmr_d   = '0;
        end
      end
      S_REF: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == TW'(REF_CYC - 1)) begin
          state_d = S_PE;
          ref_d   = 1'b0;
          pe_d    = 1'b1;
          tmr_d   = '0;
        end
      end
      S_PE: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == TW'(PE_CYC - 1)) begin
          state_d    = S_SEARCH;
          pe_d       = 1'b0;
          cand_d     = 1'b1;
          col_d      = '0;
          row_d      = '0;
          rx_col_d   = '0;
          rx_row_d   = '0;
          inflight_d = '0;
          min_d      = '1;
          min_x_d    = '0;
          min_y_d    = '0;
`ifdef BSC_EARLY_TERM_EN
          et_d       = 1'b0;
`endif
        end
      end
      S_SEARCH: begin
        if (last_cand || et_hit) begin
          state_d = S_DRAIN;
          cand_d  = 1'b0;
`ifdef BSC_EARLY_TERM_EN
          et_d    = et_hit && !last_cand;
`endif
        end else if (col_q == CW'(SR_W - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          best_sad_d = min_d;
          best_x_d   = min_x_d;
          best_y_d   = min_y_d;
`ifdef BSC_EARLY_TERM_EN
          early_d    = et_q;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef BSC_EARLY_TERM_EN
        early_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rx_col_q   <= '0;
      rx_row_q   <= '0;
      inflight_q <= '0;
      min_q      <= '1;
      min_x_q    <= '0;
      min_y_q    <= '0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
      ref_q      <= 1'b0;
      pe_q       <= 1'b0;
      cand_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BSC_EARLY_TERM_EN
      et_q       <= 1'b0;
      early_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rx_col_q   <= rx_col_d;
      rx_row_q   <= rx_row_d;
      inflight_q <= inflight_d;
      min_q      <= min_d;
      min_x_q    <= min_x_d;
      min_y_q    <= min_y_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      ref_q      <= ref_d;
      pe_q       <= pe_d;
      cand_q     <= cand_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef BSC_EARLY_TERM_EN
      et_q       <= et_d;
      early_q    <= early_d;
`endif
    end
  end

  assign eng.ref_begin_prepare   = ref_q;
  assign eng.pe_begin_prepare    = pe_q;
  assign eng.cand_valid          = cand_q;
  assign eng.search_column_count = col_q;
  assign eng.search_row_count    = row_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign best_sad  = best_sad_q;
  assign best_mv_x = best_x_q;
  assign best_mv_y = best_y_q;
`ifdef BSC_EARLY_TERM_EN
  assign early_term = early_q;
`endif
endmodule

// File: tb/tb_basic_search_ctrl.sv
// tb/tb_basic_search_ctrl.sv - self-checking bench for basic_search_ctrl
// Engine is a PIPE_LAT-deep delay line reading a SAD table indexed by raster position.
module tb_basic_search_ctrl;
  localparam int SR_W = 16, SR_H = 16, REF_CYC = 32, PE_CYC = 8, PIPE_LAT = 4, SAD_W = 16;
  localparam int NC = SR_W * SR_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic [SAD_W-1:0] best_sad;
  logic [3:0] best_mv_x, best_mv_y;
`ifdef BSC_EARLY_TERM_EN
  logic [SAD_W-1:0] et_thresh = '0;
  logic early_term;
`endif

  always #5 clk = ~clk;

  basic_search_ctrl_if #(.SR_W(SR_W), .SR_H(SR_H), .SAD_W(SAD_W)) eng ();

  basic_search_ctrl #(
    .SR_W(SR_W), .SR_H(SR_H), .REF_CYC(REF_CYC), .PE_CYC(PE_CYC),
    .PIPE_LAT(PIPE_LAT), .SAD_W(SAD_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .eng(eng),
`ifdef BSC_EARLY_TERM_EN
    .et_thresh(et_thresh), .early_term(early_term),
`endif
    .busy(busy), .done(done), .best_sad(best_sad),
    .best_mv_x(best_mv_x), .best_mv_y(best_mv_y)
  );

  logic [SAD_W-1:0] sad_mem [NC];
  logic             pv [PIPE_LAT];
  logic [SAD_W-1:0] pd [PIPE_LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= eng.cand_valid;
      for (int i = 1; i < PIPE_LAT; i++) pv[i] <= pv[i-1];
    end
    pd[0] <= sad_mem[{eng.search_row_count, eng.search_column_count}];
    for (int i = 1; i < PIPE_LAT; i++) pd[i] <= pd[i-1];
  end
  assign eng.sad_valid = pv[PIPE_LAT-1];
  assign eng.sad32x32  = pd[PIPE_LAT-1];

  int ref_n = 0, pe_n = 0, cand_n = 0, done_n = 0, order_err = 0, run_idx = 0, last_idx = -1;
  always @(negedge clk) begin
    if (eng.ref_begin_prepare === 1'b1) ref_n++;
    if (eng.pe_begin_prepare === 1'b1) pe_n++;
    if (eng.cand_valid === 1'b1) begin
      if (int'({eng.search_row_count, eng.search_column_count}) != run_idx) order_err++;
      last_idx = int'({eng.search_row_count, eng.search_column_count});
      run_idx++;
      cand_n++;
    end else begin
      run_idx = 0;
    end
    if (done === 1'b1) done_n++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Raster scan with strict-less update; early stop trims the issued prefix.
  function automatic void model(input int thr_en, input int thr, output int bs, output int bx,
                                output int by, output int issued, output int early);
    issued = NC;
    early = 0;
    if (thr_en != 0) begin
      for (int i = 0; i < NC; i++) begin
        if (int'(sad_mem[i]) <= thr) begin
          if (i + PIPE_LAT + 1 < NC) begin
            issued = i + PIPE_LAT + 1;
            early = 1;
          end
          break;
        end
      end
    end
    bs = 65535; bx = 0; by = 0;
    for (int i = 0; i < issued; i++) begin
      if (int'(sad_mem[i]) < bs) begin
        bs = int'(sad_mem[i]);
        bx = i % SR_W;
        by = i / SR_W;
      end
    end
  endfunction

  function automatic int cur_thr_en();
`ifdef BSC_EARLY_TERM_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic int cur_thr();
`ifdef BSC_EARLY_TERM_EN
    return int'(et_thresh);
`else
    return 0;
`endif
  endfunction

  task automatic wait_done(output bit to_, output bit et_seen);
    to_ = 1'b1;
    et_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        to_ = 1'b0;
`ifdef BSC_EARLY_TERM_EN
        et_seen = early_term;
`endif
        break;
      end
      cyc(1);
    end
  endtask

  task automatic do_search(output bit to_, output bit et_seen);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done(to_, et_seen);
    cyc(1);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < NC; i++) sad_mem[i] = SAD_W'($urandom_range(hi, lo));
  endtask

  task automatic test_reset();
    int s;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    s = ref_n + pe_n + cand_n + done_n;
    cyc(20);
    n_chk++;
    if ({busy, done, eng.ref_begin_prepare, eng.pe_begin_prepare, eng.cand_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl_outs: got %b want 00000",
               {busy, done, eng.ref_begin_prepare, eng.pe_begin_prepare, eng.cand_valid});
    end
    n_chk++;
    if (best_sad !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_best_sad: got %h want ffff", best_sad);
    end
    n_chk++;
    if ({best_mv_x, best_mv_y, eng.search_column_count, eng.search_row_count} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mv_counts: got %h want 0",
               {best_mv_x, best_mv_y, eng.search_column_count, eng.search_row_count});
    end
    n_chk++;
    if (ref_n + pe_n + cand_n + done_n - s !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_activity: got %0d want 0", ref_n + pe_n + cand_n + done_n - s);
    end
  endtask

  task automatic test_single_min();
    int sr, sp, sc, sd, so;
    bit to_, es;
    for (int i = 0; i < NC; i++) sad_mem[i] = 16'd1000;
    sad_mem[9*SR_W + 5] = 16'd37;
    sr = ref_n; sp = pe_n; sc = cand_n; sd = done_n; so = order_err;
    do_search(to_, es);
    n_chk++;
    if (to_) begin n_fail++; $display("FAIL single_timeout: got timeout want done"); end
    n_chk++;
    if (ref_n - sr !== REF_CYC) begin
      n_fail++; $display("FAIL single_ref_cycles: got %0d want %0d", ref_n - sr, REF_CYC);
    end
    n_chk++;
    if (pe_n - sp !== PE_CYC) begin
      n_fail++; $display("FAIL single_pe_cycles: got %0d want %0d", pe_n - sp, PE_CYC);
    end
    n_chk++;
    if (cand_n - sc !== NC) begin
      n_fail++; $display("FAIL single_cand_count: got %0d want %0d", cand_n - sc, NC);
    end
    n_chk++;
    if (done_n - sd !== 1) begin
      n_fail++; $display("FAIL single_done_count: got %0d want 1", done_n - sd);
    end
    n_chk++;
    if (order_err - so !== 0) begin
      n_fail++; $display("FAIL single_raster_order: got %0d errors want 0", order_err - so);
    end
    n_chk++;
    if ({best_sad, best_mv_x, best_mv_y} !== {16'd37, 4'd5, 4'd9}) begin
      n_fail++;
      $display("FAIL single_result: got sad=%0d mv=(%0d,%0d) want sad=37 mv=(5,9)",
               best_sad, best_mv_x, best_mv_y);
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_tie();
    bit to_, es;
    for (int i = 0; i < NC; i++) sad_mem[i] = 16'd200;
    do_search(to_, es);
    n_chk++;
    if (to_ || {best_sad, best_mv_x, best_mv_y} !== {16'd200, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL tie_result: got sad=%0d mv=(%0d,%0d) to=%0d want sad=200 mv=(0,0) to=0",
               best_sad, best_mv_x, best_mv_y, to_);
    end
  endtask

  task automatic test_random();
    int bs, bx, by, iss, ea, sc;
    bit to_, es;
    for (int it = 0; it < 4; it++) begin
      fill_random(1, (it % 2 == 0) ? 300 : 65535);
      model(cur_thr_en(), cur_thr(), bs, bx, by, iss, ea);
      sc = cand_n;
      do_search(to_, es);
      n_chk++;
      if (to_) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout want done", it); end
      n_chk++;
      if (int'(best_sad) !== bs) begin
        n_fail++; $display("FAIL rand%0d_best_sad: got %0d want %0d", it, best_sad, bs);
      end
      n_chk++;
      if (int'(best_mv_x) !== bx || int'(best_mv_y) !== by) begin
        n_fail++;
        $display("FAIL rand%0d_mv: got (%0d,%0d) want (%0d,%0d)", it, best_mv_x, best_mv_y, bx, by);
      end
      n_chk++;
      if (cand_n - sc !== iss) begin
        n_fail++; $display("FAIL rand%0d_cand_count: got %0d want %0d", it, cand_n - sc, iss);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sd, sc, bs, bx, by, iss, ea;
    bit to_, es;
    fill_random(1, 1000);
    sd = done_n; sc = cand_n;
    start = 1'b1;
    wait_done(to_, es);
    start = 1'b0;
    cyc(20);
    n_chk++;
    if (to_ || done_n - sd !== 1 || cand_n - sc !== NC) begin
      n_fail++;
      $display("FAIL hold_single_search: got done=%0d cand=%0d to=%0d want done=1 cand=%0d to=0",
               done_n - sd, cand_n - sc, to_, NC);
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy_idle: got %b want 0", busy); end

    fill_random(1, 65535);
    model(cur_thr_en(), cur_thr(), bs, bx, by, iss, ea);
    sd = done_n;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done(to_, es);
    // Done cycle: raise start so it is present in the following IDLE cycle.
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    n_chk++;
    if ({busy, eng.ref_begin_prepare} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_restart: got busy,ref=%b want 11", {busy, eng.ref_begin_prepare});
    end
    n_chk++;
    if (int'(best_sad) !== bs) begin
      n_fail++; $display("FAIL b2b_first_result: got %0d want %0d", best_sad, bs);
    end
    wait_done(to_, es);
    cyc(1);
    n_chk++;
    if (to_ || done_n - sd !== 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d to=%0d want 2", done_n - sd, to_);
    end
  endtask

  task automatic test_reset_mid();
    int sc, sd, bs, bx, by, iss, ea;
    bit to_, es, reached;
    fill_random(1, 65535);
    sc = cand_n;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (cand_n - sc >= 100) begin reached = 1'b1; break; end
      cyc(1);
    end
    n_chk++;
    if (!reached) begin n_fail++; $display("FAIL midrst_reach: got %0d want 100", cand_n - sc); end
    sd = done_n;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_chk++;
    if ({busy, eng.ref_begin_prepare, eng.pe_begin_prepare, eng.cand_valid, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_outs: got %b want 00000",
               {busy, eng.ref_begin_prepare, eng.pe_begin_prepare, eng.cand_valid, done});
    end
    n_chk++;
    if (best_sad !== 16'hFFFF) begin
      n_fail++; $display("FAIL midrst_best_sad: got %h want ffff", best_sad);
    end
    cyc(50);
    n_chk++;
    if (done_n - sd !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_done: got done=%0d busy=%b want 0 0", done_n - sd, busy);
    end
    fill_random(1, 65535);
    model(cur_thr_en(), cur_thr(), bs, bx, by, iss, ea);
    sc = cand_n;
    do_search(to_, es);
    n_chk++;
    if (to_ || cand_n - sc !== NC) begin
      n_fail++; $display("FAIL midrst_rerun_cand: got %0d to=%0d want %0d", cand_n - sc, to_, NC);
    end
    n_chk++;
    if ({int'(best_sad), int'(best_mv_x), int'(best_mv_y)} !== {bs, bx, by}) begin
      n_fail++;
      $display("FAIL midrst_rerun_result: got sad=%0d mv=(%0d,%0d) want sad=%0d mv=(%0d,%0d)",
               best_sad, best_mv_x, best_mv_y, bs, bx, by);
    end
  endtask

`ifdef BSC_EARLY_TERM_EN
  task automatic test_early_term();
    int sc, bs, bx, by, iss, ea;
    bit to_, es;
    et_thresh = 16'd50;
    fill_random(100, 65535);
    sad_mem[3] = 16'd40;
    model(1, 50, bs, bx, by, iss, ea);
    sc = cand_n;
    do_search(to_, es);
    n_chk++;
    if (to_ || es !== 1'b1 || ea !== 1) begin
      n_fail++; $display("FAIL et_flag: got early=%b to=%0d want early=1 to=0", es, to_);
    end
    n_chk++;
    if (cand_n - sc !== iss || last_idx !== 3 + PIPE_LAT) begin
      n_fail++;
      $display("FAIL et_issue_stop: got cand=%0d last=%0d want cand=%0d last=%0d",
               cand_n - sc, last_idx, iss, 3 + PIPE_LAT);
    end
    n_chk++;
    if ({best_sad, best_mv_x, best_mv_y} !== {16'd40, 4'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL et_result: got sad=%0d mv=(%0d,%0d) want sad=40 mv=(3,0)",
               best_sad, best_mv_x, best_mv_y);
    end
    et_thresh = '0;
  endtask
`endif

  initial begin
    for (int i = 0; i < NC; i++) sad_mem[i] = '1;
    test_reset();
    test_single_min();
    test_tie();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef BSC_EARLY_TERM_EN
    test_early_term();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
